// File: rtl/chaos_snd_gen.sv
// ---------------------------------------------------------------------------
// chaos_snd_gen
//
// Chaotic-map sonifier. A fixed-point map iterates once every ITER_LEN
// cycles. The map is logistic by default, or tent when built with
// CHAOS_SND_TENT_EN. Each new x retunes one of N_OSC square-wave NCOs in
// round-robin order. The map parameter r sweeps slowly upward and either
// wraps or ping-pongs at its limits. The NCO outputs are summed and
// sigma-delta modulated onto one PWM pin.
//
// Build option:
//   CHAOS_SND_TENT_EN  defined: mode 01 selects the tent map.
//                      undefined: no tent datapath; mode 01 == logistic.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high reset
//   mode      in   [1:0] 00 logistic, 01 tent, 10 hold, 11 logistic
//   pingpong  in   1: sweep reverses at r limits, 0: sweep wraps
//   r_load    in   one-cycle strobe, load r from r_in (clamped)
//   r_in      in   [FRAC+1:0] r to load, 2.FRAC format
//   r_out     out  [FRAC+1:0] current r
//   x_out     out  [FRAC-1:0] current x, 0.FRAC format
//   x_valid   out  one-cycle pulse on the cycle x_out takes a new value.
//                  There is no back-pressure: each pulse is a one-shot
//                  event that a consumer must capture on that cycle.
//   snd       out  PWM audio
// ---------------------------------------------------------------------------
module chaos_snd_gen #(
    parameter int N_OSC      = 4,
    parameter int FRAC       = 8,
    parameter int ITER_LEN   = 100,
    parameter int R_INC      = 1000,
    parameter int PHASE_BITS = 12,
    parameter int PHASE_DIV  = 64,
    parameter int LO_INC     = 2,
    parameter int HI_INC     = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic            pingpong,
    input  logic            r_load,
    input  logic [FRAC+1:0] r_in,
    output logic [FRAC+1:0] r_out,
    output logic [FRAC-1:0] x_out,
    output logic            x_valid,
    output logic            snd
);

    localparam int RW = FRAC + 2;          // r width, 2.FRAC
    localparam int XW = FRAC + 3;          // raw map result before clamping
    localparam int LW = 3 * FRAC + 3;      // full logistic product
    localparam int FW = PHASE_BITS + FRAC; // frequency scaling product
    localparam int IW = $clog2(ITER_LEN);
    localparam int SW = (R_INC > 1) ? $clog2(R_INC) : 1;
    localparam int DW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam int NW = $clog2(N_OSC);
    localparam int AW = $clog2(2 * N_OSC) + 1;

    localparam logic [RW-1:0]   R_MIN  = RW'((1 << FRAC) + (1 << (FRAC - 4)));
    localparam logic [RW-1:0]   R_MAX  = RW'((1 << RW) - 1);
    localparam logic [FRAC-1:0] X_INIT = FRAC'(1 << (FRAC - 1));
    localparam logic [FRAC-1:0] X_MAX  = FRAC'((1 << FRAC) - 1);
    localparam logic [FRAC:0]   X_ONE  = (FRAC+1)'(1 << FRAC);
    localparam logic [1:0]      MODE_HOLD = 2'b10;

    // State
    logic [IW-1:0]         r_iter;
    logic [RW-1:0]         r_rval;
    logic [FRAC-1:0]       r_x;
    logic                  r_xv;
    logic [SW-1:0]         r_sw;
    logic                  r_dir;     // 0 up, 1 down
    logic [NW-1:0]         r_fidx;
    logic [DW-1:0]         r_div;
    logic [AW-1:0]         r_acc;
    logic                  r_snd;
    logic [PHASE_BITS-1:0] r_freq  [N_OSC];
    logic [PHASE_BITS-1:0] r_phase [N_OSC];

    // Iteration timing
    logic w_iter_end;
    logic w_do_iter;
    logic w_div_tick;
    assign w_iter_end = (r_iter == IW'(ITER_LEN - 1));
    assign w_do_iter  = w_iter_end && (mode != MODE_HOLD);
    assign w_div_tick = (r_div == DW'(PHASE_DIV - 1));

    // Logistic map: r * x * (1 - x), full-width product before the shift
    logic [FRAC:0] w_x_cmp;
    logic [LW-1:0] w_log_prod;
    logic [XW-1:0] w_log_res;
    logic [XW-1:0] w_map_res;
    assign w_x_cmp    = X_ONE - {1'b0, r_x};
    assign w_log_prod = LW'(r_rval) * LW'(r_x) * LW'(w_x_cmp);
    assign w_log_res  = XW'(w_log_prod >> (2 * FRAC));

`ifdef CHAOS_SND_TENT_EN
    // Tent map with mu = r/2: the extra shift by one folds in the halving.
    localparam int TW = 2 * FRAC + 3;
    localparam logic [1:0] MODE_TENT = 2'b01;
    logic [FRAC:0] w_x_min;
    logic [TW-1:0] w_tent_prod;
    logic [XW-1:0] w_tent_res;
    assign w_x_min     = ({1'b0, r_x} < w_x_cmp) ? {1'b0, r_x} : w_x_cmp;
    assign w_tent_prod = TW'(r_rval) * TW'(w_x_min);
    assign w_tent_res  = XW'(w_tent_prod >> (FRAC + 1));
    assign w_map_res   = (mode == MODE_TENT) ? w_tent_res : w_log_res;
`else
    assign w_map_res   = w_log_res;
`endif

    // Clamp away from 0 so the map can never lock onto the zero fixed point.
    logic [FRAC-1:0] w_x_next;
    always_comb begin
        w_x_next = w_map_res[FRAC-1:0];
        if (w_map_res == '0) begin
            w_x_next = FRAC'(1);
        end else if (w_map_res > XW'(X_MAX)) begin
            w_x_next = X_MAX;
        end
    end

    // New NCO increment derived from the new x
    logic [FW-1:0]         w_freq_prod;
    logic [PHASE_BITS-1:0] w_freq_new;
    assign w_freq_prod = FW'(HI_INC - LO_INC) * FW'(w_x_next);
    assign w_freq_new  = PHASE_BITS'(LO_INC) + PHASE_BITS'(w_freq_prod >> FRAC);

    // Sweep step. Finer steps above r = 3.0 where the map is most chaotic.
    // A down direction only counts while pingpong is set, so clearing
    // pingpong sends the next step upward.
    logic [RW-1:0] w_step;
    logic [RW:0]   w_r_up;
    logic [RW:0]   w_r_dn;
    logic [RW-1:0] w_r_swept;
    logic          w_dir_swept;
    always_comb begin
        w_step      = (r_rval[FRAC+1:FRAC] == 2'b11) ? RW'(1) : RW'(4);
        w_r_up      = {1'b0, r_rval} + {1'b0, w_step};
        w_r_dn      = {1'b0, r_rval} - {1'b0, w_step};
        w_r_swept   = r_rval;
        w_dir_swept = r_dir;
        if (r_dir && pingpong) begin
            if (w_r_dn < {1'b0, R_MIN}) begin
                w_r_swept   = R_MIN;
                w_dir_swept = 1'b0;
            end else begin
                w_r_swept   = w_r_dn[RW-1:0];
                w_dir_swept = 1'b1;
            end
        end else if (w_r_up > {1'b0, R_MAX}) begin
            w_r_swept   = pingpong ? R_MAX : R_MIN;
            w_dir_swept = pingpong;
        end else begin
            w_r_swept   = w_r_up[RW-1:0];
            w_dir_swept = 1'b0;
        end
    end

    // r_in can never exceed R_MAX (all ones), so only the low side clamps.
    logic [RW-1:0] w_r_load_val;
    assign w_r_load_val = (r_in < R_MIN) ? R_MIN : r_in;

    // Oscillator outputs and their population count
    logic [AW-1:0] w_pop;
    logic [AW-1:0] w_acc_sum;
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_OSC; i++) begin
            w_pop = w_pop + AW'(r_phase[i][PHASE_BITS-1]);
        end
    end
    assign w_acc_sum = r_acc + w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iter <= '0;
            r_rval <= R_MIN;
            r_x    <= X_INIT;
            r_xv   <= 1'b0;
            r_sw   <= '0;
            r_dir  <= 1'b0;
            r_fidx <= '0;
            r_div  <= '0;
            r_acc  <= '0;
            r_snd  <= 1'b0;
            for (int i = 0; i < N_OSC; i++) begin
                r_freq[i]  <= PHASE_BITS'(LO_INC);
                r_phase[i] <= '0;
            end
        end else begin
            r_xv <= 1'b0;

            // Iteration counter free-runs in every mode, including hold.
            if (w_iter_end) begin
                r_iter <= '0;
            end else begin
                r_iter <= r_iter + IW'(1);
            end

            if (w_do_iter) begin
                r_x  <= w_x_next;
                r_xv <= 1'b1;
                r_freq[r_fidx] <= w_freq_new;
                r_fidx <= (r_fidx == NW'(N_OSC - 1)) ? '0 : r_fidx + NW'(1);
                if (r_sw == SW'(R_INC - 1)) begin
                    r_sw   <= '0;
                    r_rval <= w_r_swept;
                    r_dir  <= w_dir_swept;
                end else begin
                    r_sw <= r_sw + SW'(1);
                end
            end

            // Placed after the sweep so a coinciding step is overridden.
            if (r_load) begin
                r_rval <= w_r_load_val;
                r_sw   <= '0;
            end

            // Shared NCO phase divider
            if (w_div_tick) begin
                r_div <= '0;
                for (int i = 0; i < N_OSC; i++) begin
                    r_phase[i] <= r_phase[i] + r_freq[i];
                end
            end else begin
                r_div <= r_div + DW'(1);
            end

            // First-order sigma-delta: duty of snd tracks popcount / N_OSC.
            if (w_acc_sum >= AW'(N_OSC)) begin
                r_snd <= 1'b1;
                r_acc <= w_acc_sum - AW'(N_OSC);
            end else begin
                r_snd <= 1'b0;
                r_acc <= w_acc_sum;
            end
        end
    end

    assign r_out   = r_rval;
    assign x_out   = r_x;
    assign x_valid = r_xv;
    assign snd     = r_snd;

endmodule

// File: tb/tb_chaos_snd_gen.sv
// ---------------------------------------------------------------------------
// tb_chaos_snd_gen
//
// Self-checking bench for chaos_snd_gen. A cycle model runs on the rising
// edge and pushes expected x values and expected snd bits into queues. A
// monitor on the falling edge pops them and compares them with the DUT.
// Directed sequences add fixed-value checks for reset, the first iteration,
// the steady state, the tent map, the sweep limits, hold, and loads.
// ---------------------------------------------------------------------------
module tb_chaos_snd_gen;

    localparam int N_OSC      = 4;
    localparam int FRAC       = 8;
    localparam int ITER_LEN   = 4;
    localparam int R_INC      = 2;
    localparam int PHASE_BITS = 8;
    localparam int PHASE_DIV  = 2;
    localparam int LO_INC     = 2;
    localparam int HI_INC     = 12;
    localparam int ONE        = 1 << FRAC;
    localparam int R_MIN_I    = (1 << FRAC) + (1 << (FRAC - 4));
    localparam int R_MAX_I    = (1 << (FRAC + 2)) - 1;

    // Clock and reset
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      mode = 2'b00;
    logic            pingpong = 1'b0;
    logic            r_load = 1'b0;
    logic [FRAC+1:0] r_in = '0;
    logic [FRAC+1:0] r_out;
    logic [FRAC-1:0] x_out;
    logic            x_valid;
    logic            snd;

    always #5 clk = ~clk;

    chaos_snd_gen #(
        .N_OSC(N_OSC), .FRAC(FRAC), .ITER_LEN(ITER_LEN), .R_INC(R_INC),
        .PHASE_BITS(PHASE_BITS), .PHASE_DIV(PHASE_DIV),
        .LO_INC(LO_INC), .HI_INC(HI_INC)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .pingpong(pingpong),
        .r_load(r_load), .r_in(r_in), .r_out(r_out), .x_out(x_out),
        .x_valid(x_valid), .snd(snd)
    );

    // Scoreboard
    int n_checks = 0;
    int n_errors = 0;
    logic [FRAC-1:0] exp_q[$];
    logic            exp_snd_q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference model
    function automatic int map_next(input int x, input int r, input logic [1:0] md);
        int raw;
        int m;
        raw = (r * x * (ONE - x)) >> (2 * FRAC);
        m = (x < ONE - x) ? x : ONE - x;
`ifdef CHAOS_SND_TENT_EN
        if (md == 2'b01) raw = (r * m) >> (FRAC + 1);
`endif
        if (md == 2'b11 && m < 0) raw = 0;  // mode 11 is plain logistic
        if (raw < 1) raw = 1;
        if (raw > ONE - 1) raw = ONE - 1;
        return raw;
    endfunction

    int m_iter, m_x, m_r, m_sw, m_dir, m_fidx, m_div, m_acc, m_snd;
    int m_freq [N_OSC];
    int m_phase [N_OSC];
    bit m_ok = 1'b0;

    always @(posedge clk) begin : model_blk
        int s, a, xn, st;
        if (reset) begin
            m_iter = 0; m_x = ONE / 2; m_r = R_MIN_I; m_sw = 0; m_dir = 0;
            m_fidx = 0; m_div = 0; m_acc = 0; m_snd = 0;
            for (int i = 0; i < N_OSC; i++) begin
                m_freq[i] = LO_INC;
                m_phase[i] = 0;
            end
            m_ok = 1'b1;
        end else begin
            s = 0;
            for (int i = 0; i < N_OSC; i++) s += (m_phase[i] >> (PHASE_BITS - 1)) & 1;
            a = m_acc + s;
            if (a >= N_OSC) begin m_snd = 1; m_acc = a - N_OSC; end
            else begin m_snd = 0; m_acc = a; end
            if (m_div == PHASE_DIV - 1) begin
                m_div = 0;
                for (int i = 0; i < N_OSC; i++) m_phase[i] = (m_phase[i] + m_freq[i]) % (1 << PHASE_BITS);
            end else begin
                m_div++;
            end
            if (m_iter == ITER_LEN - 1) begin
                m_iter = 0;
                if (mode != 2'b10) begin
                    xn = map_next(m_x, m_r, mode);
                    m_x = xn;
                    exp_q.push_back(FRAC'(xn));
                    m_freq[m_fidx] = LO_INC + (((HI_INC - LO_INC) * xn) >> FRAC);
                    m_fidx = (m_fidx + 1) % N_OSC;
                    m_sw++;
                    if (m_sw == R_INC) begin
                        m_sw = 0;
                        st = (m_r >= 3 * ONE) ? 1 : 4;
                        if (pingpong && m_dir == 1) begin
                            if (m_r - st < R_MIN_I) begin m_r = R_MIN_I; m_dir = 0; end
                            else m_r = m_r - st;
                        end else begin
                            m_dir = 0;
                            if (m_r + st > R_MAX_I) begin
                                if (pingpong) begin m_r = R_MAX_I; m_dir = 1; end
                                else m_r = R_MIN_I;
                            end else begin
                                m_r = m_r + st;
                            end
                        end
                    end
                end
            end else begin
                m_iter++;
            end
            if (r_load) begin
                m_r = (int'(r_in) < R_MIN_I) ? R_MIN_I : int'(r_in);
                m_sw = 0;
            end
        end
        if (m_ok) exp_snd_q.push_back(m_snd[0]);
    end

    // Monitor
    always @(negedge clk) begin
        if (m_ok) begin
            if (exp_snd_q.size() > 0) check_val("snd", snd, exp_snd_q.pop_front());
            check_val("r_out", r_out, m_r);
            if (x_valid) begin
                if (exp_q.size() == 0) check_val("xv_extra", x_valid, 0);
                else check_val("x_out", x_out, exp_q.pop_front());
            end else if (exp_q.size() != 0) begin
                check_val("xv_missing", x_valid, 1);
                exp_q.delete();
            end
        end
    end

    // Driver tasks (inputs change on the falling edge)
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_xv();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (x_valid) begin seen = 1'b1; break; end
        end
        if (!seen) check_val("xv_timeout", x_valid, 1);
    endtask

    task automatic load_r(input logic [FRAC+1:0] v);
        r_in = v;
        r_load = 1'b1;
        @(negedge clk);
        r_load = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check_val({tag, "_x"}, x_out, 'h80);
        check_val({tag, "_r"}, r_out, 'h110);
        check_val({tag, "_xv"}, x_valid, 0);
        check_val({tag, "_snd"}, snd, 0);
    endtask

    task automatic first_iter_checks(input string tag);
        int edges;
        edges = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            edges++;
            if (x_valid) break;
        end
        check_val({tag, "_edges"}, edges, 4);
        check_val({tag, "_x"}, x_out, 'h44);
    endtask

    initial begin : stim
        int cnt;
        // Reset values and first iteration
        do_reset();
        reset_checks("rst");
        first_iter_checks("first");

        // Steady state at r = 2.0, x = 0.5
        do_reset();
        load_r(10'h200);
        for (int k = 0; k < 3; k++) begin
            wait_xv();
            check_val("steady_x", x_out, 'h80);
            load_r(10'h200);
        end

        // Tent vs logistic from x = 0x40 with r = 3.0
        do_reset();
        wait_xv();
        load_r(10'h149);
        wait_xv();
        check_val("pre_tent_x", x_out, 'h40);
        mode = 2'b01;
        load_r(10'h300);
        wait_xv();
`ifdef CHAOS_SND_TENT_EN
        check_val("tent_x", x_out, 'h60);
`else
        check_val("tent_x", x_out, 'h90);
`endif
        mode = 2'b00;

        // Sweep, wrapping
        do_reset();
        pingpong = 1'b0;
        repeat (2) wait_xv();
        check_val("sweep_r1", r_out, 'h114);
        load_r(10'h3FE);
        repeat (2) wait_xv();
        check_val("wrap_r1", r_out, 'h3FF);
        repeat (2) wait_xv();
        check_val("wrap_r2", r_out, 'h110);

        // Sweep, ping-pong
        pingpong = 1'b1;
        load_r(10'h3FE);
        repeat (2) wait_xv();
        check_val("pp_r1", r_out, 'h3FF);
        repeat (2) wait_xv();
        check_val("pp_r2", r_out, 'h3FF);
        repeat (2) wait_xv();
        check_val("pp_r3", r_out, 'h3FE);
        load_r(10'h112);
        repeat (2) wait_xv();
        check_val("pp_floor", r_out, 'h110);
        repeat (2) wait_xv();
        check_val("pp_up", r_out, 'h114);
        load_r(10'h3FF);
        repeat (2) wait_xv();
        check_val("pp_top", r_out, 'h3FF);
        pingpong = 1'b0;
        repeat (2) wait_xv();
        check_val("pp_force_up", r_out, 'h110);

        // Hold
        wait_xv();
        mode = 2'b10;
        cnt = 0;
        for (int i = 0; i < 3 * ITER_LEN; i++) begin
            @(negedge clk);
            if (x_valid) cnt++;
        end
        check_val("hold_xv_cnt", cnt, 0);
        check_val("hold_x", x_out, m_x);
        load_r(10'h050);
        check_val("hold_load_lo", r_out, 'h110);
        load_r(10'h3FF);
        check_val("hold_load_hi", r_out, 'h3FF);
        mode = 2'b00;

        // Load coinciding with a sweep step: load wins, x uses the old r
        do_reset();
        wait_xv();
        repeat (3) @(negedge clk);
        load_r(10'h200);
        check_val("coin_xv", x_valid, 1);
        check_val("coin_x", x_out, 'h35);
        check_val("coin_r", r_out, 'h200);

        // Random stimulus
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            r_load = 1'b0;
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) pingpong = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                r_in = 10'($urandom_range(0, 1023));
                r_load = 1'b1;
            end
        end
        @(negedge clk);
        r_load = 1'b0;
        mode = 2'b00;
        pingpong = 1'b0;

        // Reset in the middle of an iteration
        repeat ($urandom_range(1, 3)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        reset_checks("midrst");
        first_iter_checks("midrst_first");

        // Long run for the NCOs and mixer
        repeat (1500) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/chaos_snd_gen.md
Name: chaos_snd_gen

Overview:
Parametrised chaotic-map sonifier and next generation of the logistic-map sound block. It iterates a fixed-point map (logistic, or optionally tent) and sweeps the parameter r. It can also freeze, ping-pong sweep, or load r externally. Each new x drives one of N_OSC square-wave NCOs round-robin, and the NCOs are mixed by a first-order sigma-delta modulator onto a single PWM audio pin.

Parameters:
N_OSC, 4, number of square-wave NCOs (2..16)
FRAC, 8, fractional bits of x (0.FRAC) and r (2.FRAC)
ITER_LEN, 100, clk cycles per map iteration (>=2)
R_INC, 1000, map iterations between r steps (>=1)
PHASE_BITS, 12, NCO phase accumulator width
PHASE_DIV, 64, clk cycles per NCO phase step
LO_INC, 2, NCO increment for x=0
HI_INC, 12, NCO increment for x=1.0 (HI_INC > LO_INC, < 2^(PHASE_BITS-1))

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mode  in  2  00 logistic, 01 tent, 10 hold, 11 = logistic
pingpong  in  1  1: sweep reverses at r limits; 0: wraps
r_load  in  1  one-cycle strobe: load r from r_in
r_in  in  FRAC+2  r value to load (2.FRAC)
r_out  out  FRAC+2  current r
x_out  out  FRAC  current x
x_valid  out  1  one-cycle pulse when x_out updates
snd  out  1  PWM audio

Behaviour:
- Constants:
  - R_MIN = 2^FRAC + 2^(FRAC-4), i.e. 1.0625.
  - R_MAX = 2^(FRAC+2)-1, i.e. 4.0-LSB.
- Reset values:
  - r=R_MIN, x=2^(FRAC-1) (0.5).
  - Iteration counter 0, sweep counter 0, direction up.
  - All freq regs = LO_INC, all phases 0.
  - f_idx=0, mixer accumulator 0.
  - x_valid=0, snd=0.
- Iteration counter runs 0..ITER_LEN-1 continuously in all modes.
  - At count ITER_LEN-1, if mode != 10: x <= x_next and x_valid=1 in the same cycle (both registered).
  - First pulse occurs on the ITER_LEN-th clock edge after reset deasserts, then every ITER_LEN cycles.
- Logistic x_next = (r*x*(2^FRAC - x)) >> 2*FRAC, using full-width intermediate.
- Tent x_next = (r*min(x, 2^FRAC - x)) >> (FRAC+1), i.e. mu = r/2.
- Both map results are clamped to [1, 2^FRAC-1], so no fixed-point collapse to 0.
- Hold (mode 10):
  - no x updates and no x_valid pulses.
  - sweep counter and r frozen; NCOs keep running.
  - r_load still honoured.
- Sweep:
  - Sweep counter increments per x_valid.
  - On the x_valid where it equals R_INC-1, it clears and r steps.
  - Step size is 4 LSB if r < 3.0 (r[FRAC+1:FRAC] != 2'b11), else 1 LSB.
  - Up step: if r + step > R_MAX, then:
    - pingpong=0: r <= R_MIN;
    - pingpong=1: r <= R_MAX and direction <= down.
  - Down step (only reachable with pingpong=1): if r - step < R_MIN, r <= R_MIN and direction <= up.
  - Clearing pingpong while direction is down forces direction up at the next step.
- r_load:
  - r <= clamp(r_in, R_MIN, R_MAX), sweep counter <= 0, direction unchanged.
  - Has priority over a coinciding sweep step; the step is discarded.
  - The new r is used by the next iteration, not by one coinciding with the load.
- Frequency update on x_valid:
  - freq[f_idx] <= LO_INC + (((HI_INC-LO_INC)*x_next) >> FRAC), using the new x.
  - f_idx wraps N_OSC-1 -> 0.
- NCOs:
  - A shared divider pulses once per PHASE_DIV cycles.
  - On each pulse every phase[i] += freq[i], mod 2^PHASE_BITS.
  - osc[i] = phase[i] MSB.
- Mixer:
  - s = popcount(osc), range 0..N_OSC.
  - acc' = acc + s.
  - If acc' >= N_OSC: snd <= 1 and acc <= acc' - N_OSC; else snd <= 0 and acc <= acc'.
  - Long-run duty of snd = s/N_OSC.
- Reset mid-operation restores all reset values on the next edge; no partial iteration survives.

Optional Feature:
CHAOS_SND_TENT_EN: when defined, mode 01 selects the tent map as above. When undefined, the tent datapath is not built and mode 01 behaves exactly as logistic (00).

Test Plan:
- Reset, mode=00, FRAC=8, ITER_LEN=4 -> first x_valid on 4th edge after reset release; x_out 0x80 -> 0x44 (r=0x110), then every 4 cycles.
- Steady-state check: r_load with r_in=0x200, x=0x80, mode=00 -> x_out stays 0x80 on every x_valid.
- Build with CHAOS_SND_TENT_EN, mode=01, r_in=0x300, x=0x40 -> next x_out=0x60. Without the macro, the same stimulus yields the logistic result.
- Sweep with R_INC=2, ITER_LEN=4:
  - after 2 x_valid pulses, r_out 0x110 -> 0x114;
  - with r_load 0x3FE and pingpong=0, successive steps give 0x3FF, then 0x110;
  - with pingpong=1, successive steps give 0x3FF, 0x3FE.
- mode=10 for 3*ITER_LEN cycles -> no x_valid, x_out and r_out constant. r_load r_in=0x050 -> r_out=0x110 (clamped); r_in=0x7FF is not representable, so test 0x3FF -> 0x3FF.
- Mixer: force freq regs so osc=4'b0011 constant (PHASE_DIV large) -> snd pattern 0,1,0,1 (duty 1/2). osc=0 -> snd 0; osc=all ones -> snd 1 continuously.
